axi_lite_reg_bank: RTL and testbench

//  Parametrised AXI4-Lite register bank. It replaces the fixed bridge-plus-logic pair that provided three RW and one RO test register.

---
 rtl/axi_lite_reg_bank.sv | 155 +++++++++++++++
 tb/tb_axi_lite_reg_bank.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite register bank: NUM_RW byte-writable registers with per-register write pulses,
// followed by NUM_RO read-only inputs; RO writes and unmapped accesses answer SLVERR.
module axi_lite_reg_bank #(
   parameter int                   NUM_RW   = 3,
   parameter int                   NUM_RO   = 1,
   parameter int                   DEC_W    = 8,
   parameter logic [NUM_RW*32-1:0] RW_RESET = '0
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [31:0]             s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [31:0]             s_axi_wdata,
   input  logic [3:0]              s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [31:0]             s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [31:0]             s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic [NUM_RW*32-1:0]    rw_out,
   input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] ro_in,
   output logic [NUM_RW-1:0]       wr_pulse
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                 r_aw_held;
   logic [DEC_W-1:0]     r_aw_idx;
   logic                 r_w_held;
   logic [31:0]          r_wdata;
   logic [3:0]           r_wstrb;
   logic                 r_bvalid;
   logic [1:0]           r_bresp;
   logic                 r_rvalid;
   logic [31:0]          r_rdata;
   logic [1:0]           r_rresp;
   logic [NUM_RW*32-1:0] r_rw_out;
   logic [NUM_RW-1:0]    r_wr_pulse;

   logic                 w_aw_hs;
   logic                 w_w_hs;
   logic                 w_ar_hs;
   logic                 w_commit;
   logic [31:0]          w_aw_idx;
   logic [31:0]          w_ar_idx;
   logic [31:0]          w_rd_data;
   logic                 w_rd_err;
   logic                 w_unused_addr;

   assign s_axi_awready = !r_aw_held && !r_bvalid;
   assign s_axi_wready  = !r_w_held && !r_bvalid;
   assign s_axi_arready = !r_rvalid;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = r_rresp;
   assign rw_out        = r_rw_out;
   assign wr_pulse      = r_wr_pulse;

   assign w_aw_hs  = s_axi_awvalid && s_axi_awready;
   assign w_w_hs   = s_axi_wvalid && s_axi_wready;
   assign w_ar_hs  = s_axi_arvalid && s_axi_arready;
   // Commit only once both halves were captured on earlier edges.
   assign w_commit = r_aw_held && r_w_held;
   assign w_aw_idx = 32'(r_aw_idx);
   assign w_ar_idx = 32'(s_axi_araddr[DEC_W+1:2]);
   assign w_rd_err = (w_ar_idx >= 32'(NUM_RW + NUM_RO));

   // Address bits outside the decoded word index alias by design.
   assign w_unused_addr = ^{s_axi_awaddr[31:DEC_W+2], s_axi_awaddr[1:0],
                            s_axi_araddr[31:DEC_W+2], s_axi_araddr[1:0]};

   // Read data selection across RW registers and RO inputs.
   always_comb begin
      w_rd_data = 32'h0000_0000;
      for (int i = 0; i < NUM_RW; i++) begin
         w_rd_data = w_rd_data | ((w_ar_idx == 32'(i)) ? r_rw_out[32*i +: 32] : 32'h0000_0000);
      end
      for (int j = 0; j < NUM_RO; j++) begin
         w_rd_data = w_rd_data | ((w_ar_idx == 32'(NUM_RW + j)) ? ro_in[32*j +: 32] : 32'h0000_0000);
      end
   end

   // Write path: independent AW/W capture, commit, and B response.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_aw_held  <= 1'b0;
         r_aw_idx   <= '0;
         r_w_held   <= 1'b0;
         r_wdata    <= 32'h0000_0000;
         r_wstrb    <= 4'b0000;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_rw_out   <= RW_RESET;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= '0;
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= s_axi_awaddr[DEC_W+1:2];
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_axi_wdata;
            r_wstrb  <= s_axi_wstrb;
         end
         if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            if (w_aw_idx < 32'(NUM_RW)) begin
               r_bresp <= RESP_OKAY;
               for (int i = 0; i < NUM_RW; i++) begin
                  r_wr_pulse[i] <= (w_aw_idx == 32'(i));
                  for (int b = 0; b < 4; b++) begin
                     if ((w_aw_idx == 32'(i)) && r_wstrb[b]) begin
                        r_rw_out[32*i+8*b +: 8] <= r_wdata[8*b +: 8];
                     end
                  end
               end
            end else begin
               r_bresp <= RESP_SLVERR;
            end
         end else if (r_bvalid && s_axi_bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // Read path: one-cycle latency, response held until rready.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_rvalid <= 1'b0;
         r_rdata  <= 32'h0000_0000;
         r_rresp  <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_err ? 32'h0000_0000 : w_rd_data;
         r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_rvalid && s_axi_rready) begin
         r_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Directed bench for axi_lite_reg_bank (NUM_RW=3, NUM_RO=1): hand-computed expectations per vector.
module tb_axi_lite_reg_bank;

   localparam logic [95:0] RST_VAL = {32'h0000_0000, 32'h0000_0000, 32'h1234_5678};

   logic        aclk = 1'b0;
   logic        areset;
   logic [31:0] s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [31:0] s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic [95:0] rw_out;
   logic [31:0] ro_in;
   logic [2:0]  wr_pulse;

   int          n_chk = 0;
   int          n_bad = 0;
   logic [95:0] exp_rw;

   axi_lite_reg_bank #(
      .NUM_RW   (3),
      .NUM_RO   (1),
      .DEC_W    (8),
      .RW_RESET (RST_VAL)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .rw_out        (rw_out),
      .ro_in         (ro_in),
      .wr_pulse      (wr_pulse)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // AW and W in the same cycle; checks response latency, bresp and pulse, then completes B.
   task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [1:0] exp_resp, input logic [2:0] exp_pulse);
      s_axi_awaddr  = addr;
      s_axi_awvalid = 1'b1;
      s_axi_wdata   = data;
      s_axi_wstrb   = strb;
      s_axi_wvalid  = 1'b1;
      tick();
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      chk({tag, "_bv_early"}, 128'(s_axi_bvalid), 128'(1'b0));
      tick();
      chk({tag, "_bvalid"}, 128'(s_axi_bvalid), 128'(1'b1));
      chk({tag, "_bresp"}, 128'(s_axi_bresp), 128'(exp_resp));
      chk({tag, "_pulse"}, 128'(wr_pulse), 128'(exp_pulse));
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      chk({tag, "_bv_done"}, 128'(s_axi_bvalid), 128'(1'b0));
      chk({tag, "_pulse_off"}, 128'(wr_pulse), 128'(3'b000));
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                     input logic [1:0] exp_resp);
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      tick();
      s_axi_arvalid = 1'b0;
      chk({tag, "_rvalid"}, 128'(s_axi_rvalid), 128'(1'b1));
      chk({tag, "_rdata"}, 128'(s_axi_rdata), 128'(exp_data));
      chk({tag, "_rresp"}, 128'(s_axi_rresp), 128'(exp_resp));
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
   endtask

   initial begin
      areset = 1'b1;
      s_axi_awaddr = 32'h0; s_axi_awvalid = 1'b0;
      s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
      s_axi_araddr = 32'h0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
      ro_in = 32'hCAFE_F00D;
      tick();
      tick();
      areset = 1'b0;

      // reset state
      exp_rw = RST_VAL;
      chk("rst_rw", 128'(rw_out), 128'(exp_rw));
      chk("rst_bvalid", 128'(s_axi_bvalid), 128'(1'b0));
      chk("rst_rvalid", 128'(s_axi_rvalid), 128'(1'b0));
      chk("rst_awready", 128'(s_axi_awready), 128'(1'b1));
      chk("rst_arready", 128'(s_axi_arready), 128'(1'b1));
      rd("rd_reset0", 32'h0, 32'h1234_5678, 2'b00);

      // AW+W together to register 1
      wr("wr1", 32'h4, 32'hAABB_CCDD, 4'b1111, 2'b00, 3'b010);
      exp_rw[63:32] = 32'hAABB_CCDD;
      chk("wr1_rw", 128'(rw_out), 128'(exp_rw));
      rd("rd_lowbits", 32'h6, 32'hAABB_CCDD, 2'b00);
      rd("rd_alias", 32'h404, 32'hAABB_CCDD, 2'b00);

      wr("wr0_clr", 32'h0, 32'h0000_0000, 4'b1111, 2'b00, 3'b001);
      exp_rw[31:0] = 32'h0000_0000;
      chk("wr0_clr_rw", 128'(rw_out), 128'(exp_rw));

      // W five cycles ahead of AW, partial strobes
      s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'b0101; s_axi_wvalid = 1'b1;
      tick();
      s_axi_wvalid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("early_w_wready", 128'(s_axi_wready), 128'(1'b0));
         chk("early_w_bvalid", 128'(s_axi_bvalid), 128'(1'b0));
         tick();
      end
      s_axi_awaddr = 32'h0; s_axi_awvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0;
      chk("early_w_bv_early", 128'(s_axi_bvalid), 128'(1'b0));
      tick();
      exp_rw[31:0] = 32'h00FF_00FF;
      chk("early_w_bvalid2", 128'(s_axi_bvalid), 128'(1'b1));
      chk("early_w_rw", 128'(rw_out), 128'(exp_rw));
      chk("early_w_pulse", 128'(wr_pulse), 128'(3'b001));
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;

      // zero strobe still answers OKAY and pulses
      wr("wr_nostrb", 32'h8, 32'hFFFF_FFFF, 4'b0000, 2'b00, 3'b100);
      chk("wr_nostrb_rw", 128'(rw_out), 128'(exp_rw));

      // RO and unmapped writes/reads
      wr("wr_ro", 32'hC, 32'h5555_5555, 4'b1111, 2'b10, 3'b000);
      chk("wr_ro_rw", 128'(rw_out), 128'(exp_rw));
      wr("wr_unmap", 32'h40, 32'h5555_5555, 4'b1111, 2'b10, 3'b000);
      chk("wr_unmap_rw", 128'(rw_out), 128'(exp_rw));
      rd("rd_unmap", 32'h40, 32'h0000_0000, 2'b10);
      rd("rd_ro", 32'hC, 32'hCAFE_F00D, 2'b00);

      // read coinciding with commit to the same register sees old value
      s_axi_awaddr = 32'h0; s_axi_wdata = 32'h1212_1212; s_axi_wstrb = 4'b1111;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      s_axi_araddr = 32'h0; s_axi_arvalid = 1'b1;
      tick();
      s_axi_arvalid = 1'b0;
      exp_rw[31:0] = 32'h1212_1212;
      chk("raw_rdata", 128'(s_axi_rdata), 128'(32'h00FF_00FF));
      chk("raw_bvalid", 128'(s_axi_bvalid), 128'(1'b1));
      chk("raw_rw", 128'(rw_out), 128'(exp_rw));
      s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      tick();
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;

      // B back-pressure: second write waits for the B handshake
      s_axi_awaddr = 32'h4; s_axi_wdata = 32'h1111_1111; s_axi_wstrb = 4'b1111;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      tick();
      s_axi_wdata = 32'h2222_2222;
      tick();
      exp_rw[63:32] = 32'h1111_1111;
      for (int k = 0; k < 10; k++) begin
         chk("bp_bvalid", 128'(s_axi_bvalid), 128'(1'b1));
         chk("bp_bresp", 128'(s_axi_bresp), 128'(2'b00));
         chk("bp_awready", 128'(s_axi_awready), 128'(1'b0));
         chk("bp_wready", 128'(s_axi_wready), 128'(1'b0));
         tick();
      end
      chk("bp_rw_hold", 128'(rw_out), 128'(exp_rw));
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      chk("bp_awready_free", 128'(s_axi_awready), 128'(1'b1));
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      tick();
      exp_rw[63:32] = 32'h2222_2222;
      chk("bp2_bvalid", 128'(s_axi_bvalid), 128'(1'b1));
      chk("bp2_rw", 128'(rw_out), 128'(exp_rw));
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;

      // R back-pressure
      s_axi_araddr = 32'h4; s_axi_arvalid = 1'b1;
      tick();
      s_axi_arvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("rbp_rvalid", 128'(s_axi_rvalid), 128'(1'b1));
         chk("rbp_rdata", 128'(s_axi_rdata), 128'(32'h2222_2222));
         chk("rbp_arready", 128'(s_axi_arready), 128'(1'b0));
         tick();
      end
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
      chk("rbp_done", 128'(s_axi_rvalid), 128'(1'b0));

      // reset with AW held and R pending
      s_axi_araddr = 32'h0; s_axi_arvalid = 1'b1;
      tick();
      s_axi_arvalid = 1'b0;
      s_axi_awaddr = 32'h4; s_axi_awvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0;
      chk("r6_aw_held", 128'(s_axi_awready), 128'(1'b0));
      areset = 1'b1;
      tick();
      areset = 1'b0;
      exp_rw = RST_VAL;
      chk("r6_rvalid", 128'(s_axi_rvalid), 128'(1'b0));
      chk("r6_awready", 128'(s_axi_awready), 128'(1'b1));
      chk("r6_rw", 128'(rw_out), 128'(exp_rw));
      s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'b1111; s_axi_wvalid = 1'b1;
      tick();
      s_axi_wvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("r6_w_bvalid", 128'(s_axi_bvalid), 128'(1'b0));
         chk("r6_w_pulse", 128'(wr_pulse), 128'(3'b000));
         tick();
      end
      chk("r6_w_rw", 128'(rw_out), 128'(exp_rw));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
